// File: rtl/readout_pkg.sv
// Shared types and constants for the ADC readout sequencer.
package readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD,
    CAP,
    SND,
    TRL,
    DONE,
    GAP
  } state_t;

  localparam logic [3:0] HDR_TAG     = 4'hA;
  localparam logic [3:0] TRL_TAG     = 4'hE;
  localparam int         DEF_NADC    = 16;
  localparam int         DEF_NSAMPLE = 64;
  localparam int         IDX_W       = 4;

endpackage

// File: rtl/adc_readout_sequencer_onehot_to_index.sv
// Lowest-set-bit encoder for the ADC select vector.
// Also flags a select that has more than one bit set.
module onehot_to_index #(
  parameter int NADC = 16,
  parameter int IDXW = 4
) (
  input  logic [NADC-1:0] vec_i,
  output logic [IDXW-1:0] idx_o,
  output logic            multi_o
);

  // Scanning downward lets the lowest set bit overwrite any higher ones.
  always_comb begin
    idx_o = '0;
    for (int i = NADC - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDXW'(i);
      end
    end
  end

  assign multi_o = |(vec_i & (vec_i - {{(NADC-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/adc_readout_sequencer.sv
// Frames NSAMPLE buffer words per ADC as header + samples + trailer on a valid/ready stream.
// Define READOUT_CHECKSUM_EN to carry an XOR checksum of the samples in the trailer.
module adc_readout_sequencer
  import readout_pkg::*;
#(
  parameter int NADC    = DEF_NADC,
  parameter int NSAMPLE = DEF_NSAMPLE,
  parameter int DW      = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NADC-1:0] start_read,
  output logic            rd_en,
  output logic [3:0]      rd_sel,
  input  logic [DW-1:0]   rd_data,
  output logic [DW-1:0]   tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            one_adc_finish_read,
  output logic [7:0]      evt_cnt,
  output logic            sel_error
);

  localparam logic [7:0]       NS8      = 8'(NSAMPLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NADC - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    tx_data_q, tx_data_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       evt_q, evt_d;
  logic             sel_err_q, sel_err_d;
  logic [11:0]      trailer;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_multi;

  onehot_to_index #(
    .NADC (NADC),
    .IDXW (IDX_W)
  ) u_enc (
    .vec_i   (start_read),
    .idx_o   (enc_idx),
    .multi_o (enc_multi)
  );

`ifdef READOUT_CHECKSUM_EN
  logic [11:0] acc_q, acc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // The accumulator already holds every sample by the time the last one is accepted.
  always_comb begin
    acc_d = acc_q;
    if (state_q == IDLE && |start_read) begin
      acc_d = '0;
    end else if (state_q == CAP) begin
      acc_d = acc_q ^ rd_data[11:0];
    end
  end

  assign trailer = acc_q;
`else
  assign trailer = {4'h0, NS8};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      evt_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      evt_q     <= evt_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    evt_d     = evt_q;
    sel_err_d = sel_err_q;

    unique case (state_q)
      IDLE: begin
        if (|start_read) begin
          idx_d     = enc_idx;
          sel_err_d = sel_err_q | enc_multi;
          cnt_d     = '0;
          tx_data_d = {HDR_TAG, enc_idx, evt_q};
          state_d   = HDR;
        end
      end
      HDR: begin
        if (tx_ready) begin
          state_d = RD;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        tx_data_d = rd_data;
        state_d   = SND;
      end
      SND: begin
        if (tx_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == NS8) begin
            tx_data_d = {TRL_TAG, trailer};
            state_d   = TRL;
          end else begin
            state_d = RD;
          end
        end
      end
      TRL: begin
        if (tx_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (idx_q == LAST_IDX) begin
          evt_d = evt_q + 8'd1;
        end
        state_d = GAP;
      end
      // Lets the manager's shifted select settle before IDLE looks at it again.
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_valid            = (state_q == HDR) || (state_q == SND) || (state_q == TRL);
  assign tx_data             = tx_data_q;
  assign rd_en               = (state_q == RD);
  assign rd_sel              = idx_q;
  assign one_adc_finish_read = (state_q == DONE);
  assign evt_cnt             = evt_q;
  assign sel_error           = sel_err_q;

endmodule

// File: tb/tb_adc_readout_sequencer.sv
// Randomized frame-level bench for adc_readout_sequencer (NSAMPLE=4, NADC=16).
// Expected frames are rebuilt from the supplied samples and a software event counter.
module tb_adc_readout_sequencer;

  localparam int NS = 4;

  logic        clk;
  logic        reset_n;
  logic [15:0] start_read;
  logic        rd_en;
  logic [3:0]  rd_sel;
  logic [15:0] rd_data;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        one_adc_finish_read;
  logic [7:0]  evt_cnt;
  logic        sel_error;

  int          tests;
  int          fails;
  int          finCount;
  int          readyMode;
  int          stallLeft;
  bit          stallArm;
  bit          fixedData;
  bit          prevStall;
  logic [15:0] prevData;
  logic [3:0]  curIdx;
  logic [7:0]  evtModel;
  logic [15:0] got[$];
  logic [15:0] sent[$];

  adc_readout_sequencer #(
    .NADC    (16),
    .NSAMPLE (NS),
    .DW      (16)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start_read          (start_read),
    .rd_en               (rd_en),
    .rd_sel              (rd_sel),
    .rd_data             (rd_data),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .one_adc_finish_read (one_adc_finish_read),
    .evt_cnt             (evt_cnt),
    .sel_error           (sel_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Buffer model, sink model and stream monitor; samples first, then drives for the next edge.
  always @(negedge clk) begin
    logic [15:0] sample;
    if (!reset_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stable_valid", {31'd0, tx_valid}, 32'd1);
        checkOutput("stable_data", {16'd0, tx_data}, {16'd0, prevData});
      end
      if (rd_en) begin
        sample  = fixedData ? 16'(16'h0100 + sent.size()) : 16'($urandom);
        rd_data = sample;
        sent.push_back(sample);
        checkOutput("rd_sel", {28'd0, rd_sel}, {28'd0, curIdx});
      end
      if (stallLeft > 0) begin
        tx_ready = 1'b0;
        stallLeft--;
      end else if (stallArm && tx_valid && got.size() == 2) begin
        stallArm  = 1'b0;
        stallLeft = 49;
        tx_ready  = 1'b0;
      end else if (readyMode == 0) begin
        tx_ready = 1'b1;
      end else if (readyMode == 1) begin
        tx_ready = ($urandom_range(0, 2) == 0);
      end else begin
        tx_ready = 1'b0;
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
      if (one_adc_finish_read) finCount++;
    end
  end

  // Runs one frame, applies the manager's next select on the finish pulse, and checks the stream.
  task automatic applyStimulus(input logic [15:0] sel, input logic [15:0] nextSel,
                               input logic [3:0] expIdx, input string tag);
    int          cycles;
    logic [15:0] expw[$];
    logic [11:0] x;
    got.delete();
    sent.delete();
    curIdx     = expIdx;
    start_read = sel;
    cycles     = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!one_adc_finish_read && cycles < 4000);
    if (!one_adc_finish_read) begin
      tests++;
      fails++;
      $error("[TB] FAIL %s_timeout: observed no finish pulse, expected one within 4000 cycles", tag);
      start_read = nextSel;
      return;
    end
    start_read = nextSel;
    checkOutput({tag, "_evt_pre"}, {24'd0, evt_cnt}, {24'd0, evtModel});
    expw.push_back({4'hA, expIdx, evtModel});
    x = '0;
    foreach (sent[i]) begin
      expw.push_back(sent[i]);
      x = x ^ sent[i][11:0];
    end
`ifdef READOUT_CHECKSUM_EN
    expw.push_back({4'hE, x});
`else
    expw.push_back({4'hE, 4'h0, 8'(NS)});
`endif
    checkOutput({tag, "_reads"}, sent.size(), NS);
    checkOutput({tag, "_wc"}, got.size(), NS + 2);
    foreach (expw[i]) begin
      checkOutput($sformatf("%s_w%0d", tag, i),
                  {16'd0, (i < got.size()) ? got[i] : 16'hxxxx}, {16'd0, expw[i]});
    end
    if (expIdx == 4'hF) evtModel = evtModel + 8'd1;
    @(negedge clk);
    checkOutput({tag, "_fin_width"}, {31'd0, one_adc_finish_read}, 32'd0);
    checkOutput({tag, "_evt_post"}, {24'd0, evt_cnt}, {24'd0, evtModel});
  endtask

  initial begin
    int cyc;
    int finSnap;
    tests      = 0;
    fails      = 0;
    finCount   = 0;
    readyMode  = 0;
    stallLeft  = 0;
    stallArm   = 1'b0;
    fixedData  = 1'b0;
    prevStall  = 1'b0;
    prevData   = '0;
    curIdx     = '0;
    evtModel   = '0;
    reset_n    = 1'b0;
    start_read = '0;
    rd_data    = '0;
    tx_ready   = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, rd_en}, 32'd0);
    checkOutput("rst_finish", {31'd0, one_adc_finish_read}, 32'd0);
    checkOutput("rst_sel_error", {31'd0, sel_error}, 32'd0);
    checkOutput("rst_tx_data", {16'd0, tx_data}, 32'd0);
    checkOutput("rst_rd_sel", {28'd0, rd_sel}, 32'd0);
    checkOutput("rst_evt_cnt", {24'd0, evt_cnt}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    fixedData = 1'b1;
    applyStimulus(16'h0001, 16'h0000, 4'd0, "single");
    checkOutput("single_hdr", {16'd0, got[0]}, 32'h0000_A000);
    checkOutput("single_s0", {16'd0, got[1]}, 32'h0000_0100);
    checkOutput("single_s3", {16'd0, got[4]}, 32'h0000_0103);
`ifdef READOUT_CHECKSUM_EN
    checkOutput("single_trl", {16'd0, got[5]}, 32'h0000_E000);
`else
    checkOutput("single_trl", {16'd0, got[5]}, 32'h0000_E004);
`endif
    checkOutput("single_fin_count", finCount, 1);
    repeat (5) @(negedge clk);
    checkOutput("idle_no_frame", {31'd0, tx_valid}, 32'd0);
    fixedData = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'(1 << i), (i < 15) ? 16'(1 << (i + 1)) : 16'h0000, 4'(i), $sformatf("sweep%0d", i));
    end
    checkOutput("sweep_evt", {24'd0, evt_cnt}, 32'd1);

    readyMode = 1;
    stallArm  = 1'b1;
    applyStimulus(16'h0001, 16'h0000, 4'd0, "bp");
    checkOutput("bp_stall_hit", {31'd0, stallArm}, 32'd0);

    applyStimulus(16'h0014, 16'h0000, 4'd2, "multi");
    checkOutput("multi_sel_error", {31'd0, sel_error}, 32'd1);
    applyStimulus(16'h0008, 16'h0000, 4'd3, "sticky");
    checkOutput("sticky_sel_error", {31'd0, sel_error}, 32'd1);

    readyMode = 0;
    got.delete();
    sent.delete();
    curIdx     = 4'd0;
    start_read = 16'h0001;
    cyc        = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(sent.size() == 3 && tx_valid) && cyc < 200);
    checkOutput("rst_mid_reached", {31'd0, tx_valid}, 32'd1);
    finSnap = finCount;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("mid_tx_data", {16'd0, tx_data}, 32'd0);
    checkOutput("mid_rd_en", {31'd0, rd_en}, 32'd0);
    checkOutput("mid_sel_error", {31'd0, sel_error}, 32'd0);
    checkOutput("mid_evt_cnt", {24'd0, evt_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("mid_finish", {31'd0, one_adc_finish_read}, 32'd0);
    checkOutput("mid_no_fin_pulse", finCount, finSnap);
    evtModel = 8'd0;
    reset_n  = 1'b1;
    applyStimulus(16'h0001, 16'h0000, 4'd0, "post_rst");

    for (int k = 0; k < 255; k++) begin
      applyStimulus(16'h8000, 16'h8000, 4'hF, $sformatf("wrap%0d", k));
    end
    checkOutput("wrap_ff", {24'd0, evt_cnt}, 32'h0000_00FF);
    applyStimulus(16'h8000, 16'h8000, 4'hF, "wrap_last");
    checkOutput("wrap_00", {24'd0, evt_cnt}, 32'd0);
    applyStimulus(16'h8000, 16'h0000, 4'hF, "wrap_after");
    checkOutput("wrap_hdr", {16'd0, got[0]}, 32'h0000_AF00);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_readout_sequencer.md
Name: adc_readout_sequencer

Overview:
- Downstream consumer of the transmit manager's one-hot `start_read` vector.
- For the selected ADC it reads NSAMPLE words from the shared event buffer and frames them as header + samples + trailer on a valid/ready transmit stream.
- When the trailer is accepted it pulses `one_adc_finish_read` so the manager shifts to the next ADC.
- Sits between the per-ADC event buffers and the link serializer.

Parameters:
- NADC, 16: number of ADCs; width of `start_read`.
- NSAMPLE, 64: sample words read per ADC per event, range 1..255.
- DW, 16: data word width; header and trailer layouts assume 16.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_read  in  NADC  one-hot ADC select from the transmit manager; all-zero means idle.
- rd_en  out  1  buffer read strobe; one word per strobe.
- rd_sel  out  4  ADC index for the buffer read.
- rd_data  in  DW  buffer data, valid exactly 1 cycle after `rd_en`.
- tx_data  out  DW  framed output word.
- tx_valid  out  1  `tx_data` valid.
- tx_ready  in  1  sink accepts the word when `tx_valid` and `tx_ready` are both high.
- one_adc_finish_read  out  1  single-cycle pulse after the trailer is accepted.
- evt_cnt  out  8  events completed (ADC NADC-1 finished); wraps 255->0.
- sel_error  out  1  sticky; set when `start_read` is non-zero and not one-hot at the IDLE sample point.

Behaviour:
- Reset (asynchronous, `reset_n`=0):
  - state=IDLE.
  - `rd_en`, `tx_valid`, `one_adc_finish_read`, `sel_error` = 0.
  - `tx_data`=0, `rd_sel`=0, `evt_cnt`=0.
  - Sample counter and checksum accumulator = 0.
  - A reset mid-frame abandons the frame; the sink sees no further words.
- IDLE: when `start_read`!=0, latch `idx` = index of the lowest set bit and go to HDR.
  - If more than one bit is set, also set `sel_error`.
- HDR: drive `tx_data`={4'hA, idx[3:0], evt_cnt[7:0]}, `tx_valid`=1.
  - Hold the word stable until accepted, then go to RD.
- RD: assert `rd_en` for 1 cycle with `rd_sel`=idx, then go to CAP.
- CAP: capture `rd_data` into `tx_data`, assert `tx_valid`, go to SND.
- SND: hold until accepted.
  - On acceptance, increment the sample counter.
  - If the counter reached NSAMPLE, go to TRL; otherwise go to RD.
  - Throughput is at best 1 word per 3 cycles; `tx_valid` never drops before acceptance.
- TRL: drive `tx_data`={4'hE, trailer12}, `tx_valid`=1.
  - On acceptance go to DONE; `tx_valid` is low in DONE.
- DONE: `one_adc_finish_read`=1 for exactly this cycle.
  - If idx==NADC-1, increment `evt_cnt` (modulo 256).
  - Go to GAP.
- GAP: 1 idle cycle so the manager's registered `start_read` shift is visible, then go to IDLE.
  - No new frame may start on the stale `start_read` value.
- Sample counter and accumulator are cleared on the IDLE->HDR transition.
- `tx_ready` held low indefinitely stalls the block in its current state. No timeout.
- `start_read` changing mid-frame is ignored; `idx` is latched.
- `start_read` falling to 0 mid-frame still completes the frame and pulses finish.

Optional Feature:
- Macro: READOUT_CHECKSUM_EN.
- Defined: trailer12 = XOR of `rd_data`[11:0] over all NSAMPLE samples of the frame, accumulated at CAP.
- Undefined: trailer12 = {4'h0, NSAMPLE[7:0]}; no accumulator is synthesized.

Decomposition:
- Shared package `readout_pkg`:
  - state enum: IDLE, HDR, RD, CAP, SND, TRL, DONE, GAP.
  - HDR_TAG=4'hA, TRL_TAG=4'hE.
  - default NADC / NSAMPLE.
- Sub-module `onehot_to_index`: combinational lowest-set-bit encoder plus multi-hot detect, parameterized on NADC.

Test Plan:
- Single ADC:
  - Stimulus: `start_read`=16'h0001, NSAMPLE=4, `rd_data`=0x100,0x101,0x102,0x103, `tx_ready`=1.
  - Required: stream A000,0100,0101,0102,0103, then E004 (or E000 with checksum: 0x100^0x101^0x102^0x103 = 0x000).
  - Required: one finish pulse, 1 cycle wide.
- Full sweep:
  - Stimulus: manager model shifts 0x0001 up to 0x8000 on each finish pulse.
  - Required: 16 frames with header idx 0..F; `evt_cnt` goes 0->1 only after the idx-F finish pulse.
  - Required: the next header carries evt 01.
- Backpressure:
  - Stimulus: `tx_ready` toggling 1-in-3 randomly, plus a 50-cycle low stall during SND.
  - Required: `tx_data` stable while `tx_valid`&&!`tx_ready`; no word lost or duplicated; word count = NSAMPLE+2.
- Multi-hot select:
  - Stimulus: `start_read`=16'h0014.
  - Required: `sel_error`=1 (sticky); header idx=2; frame completes normally.
- Reset mid-frame:
  - Stimulus: `reset_n` low during the 3rd sample SND.
  - Required: `tx_valid` drops asynchronously; all outputs at reset values; no finish pulse.
  - Required: after release with `start_read`=16'h0001, a fresh header with evt 00 appears.
- Counter wrap:
  - Stimulus: 256 full sweeps.
  - Required: `evt_cnt` reads FF, then 00; header evt field follows it.
